// File: rtl/johnson_checker.sv
// Watches a parallel Johnson-coded bus, locks onto its step sequence and flags illegal codes, skips and stalls.
// Latency: IN_P is captured on edge 1; outputs reflect that sample on edge 2.
// Backpressure: none; every cycle is sampled, and ENABLE only qualifies the stall timer.
module johnson_checker #(
    parameter int width  = 10,
    parameter int modulo = 10
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             ENABLE,
    input  logic [width-1:0] IN_P,
    input  logic             CLEAR,
    output logic [4:0]       INDEX,
    output logic             VALID,
    output logic             LOCKED,
    output logic             STEP,
    output logic             ERROR,
    output logic [7:0]       LAPS
);
    // Last legal position and the last ENABLE count before a stall becomes an error.
    localparam logic [4:0] LAST_IDX = 5'(2 * width - 1);
    localparam logic [8:0] TMO_LAST = 9'(2 * modulo - 1);

    typedef enum logic [1:0] {
        ST_HUNT  = 2'd0,
        ST_CHECK = 2'd1,
        ST_ERROR = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [width-1:0] s1;
    logic [width-1:0] s2;
    // s1 holds a real sample, not the reset value.
    logic             s1_vld;
    // The first real sample has already been offered to the hunt.
    logic             first_done;
    logic [8:0]       tmo_cnt;
    logic [4:0]       expected;

    logic             code_legal;
    logic [4:0]       code_idx;
    logic [width-1:0] pat;
    logic             change;
    logic             first_smp;
    logic             lock_now;
    logic             good_step;
    logic             timeout;
    logic [4:0]       idx_next;

    // Decode s1 by comparing it with each of the 2*width legal patterns.
    always_comb begin
        code_legal = 1'b0;
        code_idx   = 5'd0;
        pat        = '0;
        for (int k = 0; k < 2 * width; k++) begin
            for (int i = 0; i < width; i++) begin
                pat[i] = (k <= width) ? (i < k) : (i >= k - width);
            end
            if (s1 == pat) begin
                code_legal = 1'b1;
                code_idx   = 5'(k);
            end
        end
    end

    assign change    = s1_vld && (s1 != s2);
    assign first_smp = s1_vld && !first_done;
    assign lock_now  = (state == ST_HUNT) && (change || first_smp) && code_legal;
    assign good_step = (state == ST_CHECK) && change && code_legal && (code_idx == expected);
    assign timeout   = (state == ST_CHECK) && !change && ENABLE && (tmo_cnt == TMO_LAST);
    assign idx_next  = (code_idx == LAST_IDX) ? 5'd0 : code_idx + 5'd1;

    // Two-stage input capture; s2 is the previous sample used to detect a change.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            s1         <= '0;
            s2         <= '0;
            s1_vld     <= 1'b0;
            first_done <= 1'b0;
        end else begin
            s1     <= IN_P;
            s2     <= s1;
            s1_vld <= 1'b1;
            if (s1_vld) begin
                first_done <= 1'b1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state <= ST_HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; CLEAR is only honoured in ERROR, so a fault seen in CHECK always wins.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_HUNT: begin
                if (lock_now) begin
                    state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if ((change && !good_step) || timeout) begin
                    state_nxt = ST_ERROR;
                end
            end
            ST_ERROR: begin
                if (CLEAR) begin
                    state_nxt = ST_HUNT;
                end
            end
            default: state_nxt = ST_HUNT;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        LOCKED = (state == ST_CHECK);
        ERROR  = (state == ST_ERROR);
    end

    // Registered outputs, the expected next index, the stall timer and the lap counter.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            INDEX    <= 5'd0;
            VALID    <= 1'b0;
            STEP     <= 1'b0;
            LAPS     <= 8'd0;
            expected <= 5'd0;
            tmo_cnt  <= 9'd0;
        end else begin
            VALID <= s1_vld && code_legal;
            if (s1_vld && code_legal) begin
                INDEX <= code_idx;
            end
            STEP <= good_step;
            if (lock_now || good_step) begin
                expected <= idx_next;
            end
            if (good_step && (code_idx == 5'd0) && (LAPS != 8'hFF)) begin
                LAPS <= LAPS + 8'd1;
            end
            case (state)
                ST_HUNT:  tmo_cnt <= 9'd0;
                ST_CHECK: begin
                    if (change) begin
                        tmo_cnt <= 9'd0;
                    end else if (ENABLE) begin
                        tmo_cnt <= tmo_cnt + 9'd1;
                    end
                end
                ST_ERROR: begin
                    if (CLEAR) begin
                        tmo_cnt <= 9'd0;
                    end
                end
                default:  tmo_cnt <= 9'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_johnson_checker.sv
// Randomised and directed bench for johnson_checker against a behavioural reference model.
// Latency: the model consumes the sample taken on the previous edge; outputs are sampled 1 time unit after each edge.
// Backpressure: none; the model advances on every clock edge while reset is released.
module tb_johnson_checker;
    localparam int W = 10;
    localparam int M = 10;
    localparam int N = 2 * W;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         enable;
    logic         clear;
    logic [W-1:0] in_p;
    logic [4:0]   index;
    logic         valid;
    logic         locked;
    logic         step;
    logic         error;
    logic [7:0]   laps;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: mode 0 = hunting, 1 = checking, 2 = error.
    int           m_mode;
    int           m_last;
    int           m_idle;
    int           m_laps;
    int           m_index;
    int           m_valid;
    int           m_step;
    int           m_nsamp;
    logic [W-1:0] m_s1;
    logic [W-1:0] m_s2;

    always #5 clk = ~clk;

    johnson_checker #(.width(W), .modulo(M)) dut (
        .CLK    (clk),
        .RSTn   (rst_n),
        .ENABLE (enable),
        .IN_P   (in_p),
        .CLEAR  (clear),
        .INDEX  (index),
        .VALID  (valid),
        .LOCKED (locked),
        .STEP   (step),
        .ERROR  (error),
        .LAPS   (laps)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Code for position k: k ones from the LSB for k <= W, otherwise ones above (k-W) low zeros.
    function automatic logic [W-1:0] jenc(input int k);
        int v;
        if (k <= W) v = (1 << k) - 1;
        else        v = ((1 << W) - 1) - ((1 << (k - W)) - 1);
        return W'(v);
    endfunction

    // Position of a code from its population count and shape, or -1 if illegal.
    function automatic int jdec(input logic [W-1:0] x);
        int v;
        int p;
        v = int'(x);
        p = $countones(x);
        if (v == (1 << p) - 1) return p;
        if (p > 0 && p < W && v == ((1 << W) - 1) - ((1 << (W - p)) - 1)) return N - p;
        return -1;
    endfunction

    task automatic model_reset();
        m_mode  = 0;
        m_last  = 0;
        m_idle  = 0;
        m_laps  = 0;
        m_index = 0;
        m_valid = 0;
        m_step  = 0;
        m_nsamp = 0;
        m_s1    = '0;
        m_s2    = '0;
    endtask

    task automatic model_edge();
        int idx;
        bit legal;
        bit chg;
        bit first;
        idx   = jdec(m_s1);
        legal = (idx >= 0);
        chg   = (m_nsamp >= 1) && (m_s1 != m_s2);
        first = (m_nsamp == 1);
        m_step = 0;
        if (m_nsamp >= 1 && legal) begin
            m_index = idx;
            m_valid = 1;
        end else begin
            m_valid = 0;
        end
        case (m_mode)
            0: if ((chg || first) && legal) begin
                   m_mode = 1;
                   m_last = idx;
                   m_idle = 0;
               end
            1: if (chg) begin
                   if (legal && idx == (m_last + 1) % N) begin
                       m_step = 1;
                       m_last = idx;
                       m_idle = 0;
                       if (idx == 0 && m_laps < 255) m_laps++;
                   end else begin
                       m_mode = 2;
                   end
               end else if (enable) begin
                   m_idle++;
                   if (m_idle == 2 * M) m_mode = 2;
               end
            default: if (clear) begin
                   m_mode = 0;
                   m_idle = 0;
               end
        endcase
        m_s2 = m_s1;
        m_s1 = in_p;
        if (m_nsamp < 2) m_nsamp++;
    endtask

    task automatic check_outputs();
        chk("index",  int'(index),  m_index);
        chk("valid",  int'(valid),  m_valid);
        chk("locked", int'(locked), (m_mode == 1) ? 1 : 0);
        chk("step",   int'(step),   m_step);
        chk("error",  int'(error),  (m_mode == 2) ? 1 : 0);
        chk("laps",   int'(laps),   m_laps);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    // Assert reset between edges, check the cleared outputs, release mid-cycle.
    task automatic do_reset();
        cyc();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    initial begin
        int cnt;
        int steps;
        int cidx;
        int r;
        rst_n  = 1'b0;
        enable = 1'b1;
        clear  = 1'b0;
        in_p   = '0;
        model_reset();
        #1;
        check_outputs();
        #11;
        rst_n = 1'b1;

        // Constant zero code: lock after two edges, then time out after 2*M enabled cycles.
        cyc();
        cyc();
        chk("hold_locked", int'(locked), 1);
        chk("hold_index",  int'(index),  0);
        chk("hold_valid",  int'(valid),  1);
        cnt = 0;
        while (!error && cnt < 40) begin
            cyc();
            cnt++;
        end
        chk("hold_timeout_cycles", cnt, 20);

        // One full lap, stepping every 10 cycles.
        in_p = '0;
        do_reset();
        cyc();
        cyc();
        steps = 0;
        for (int k = 1; k <= N; k++) begin
            in_p = jenc(k % N);
            repeat (10) begin
                cyc();
                steps += int'(step);
            end
        end
        chk("lap_steps", steps, 20);
        chk("lap_laps",  int'(laps),  1);
        chk("lap_error", int'(error), 0);

        // Skip from index 3 to index 5.
        for (int k = 1; k <= 3; k++) begin
            in_p = jenc(k);
            repeat (3) cyc();
        end
        in_p = jenc(5);
        cyc();
        cyc();
        chk("skip_error",  int'(error),  1);
        chk("skip_locked", int'(locked), 0);
        chk("skip_index",  int'(index),  5);
        chk("skip_step",   int'(step),   0);

        // CLEAR out of error with all-ones: hunt, then lock on index 10.
        clear = 1'b1;
        in_p  = '1;
        cyc();
        clear = 1'b0;
        chk("clr_hunt_locked", int'(locked), 0);
        chk("clr_hunt_error",  int'(error),  0);
        cyc();
        chk("clr_locked", int'(locked), 1);
        chk("clr_index",  int'(index),  10);
        chk("clr_error",  int'(error),  0);
        chk("clr_laps",   int'(laps),   1);

        // Illegal code while checking: error, VALID low, INDEX held.
        in_p = W'(5);
        cyc();
        cyc();
        chk("illegal_error", int'(error), 1);
        chk("illegal_valid", int'(valid), 0);
        chk("illegal_index", int'(index), 10);

        // Random mix of steps, holds, jumps, illegal codes, ENABLE and CLEAR.
        cidx = 0;
        for (int t = 0; t < 3000; t++) begin
            r      = $urandom_range(0, 99);
            enable = 1'($urandom_range(0, 1));
            clear  = ($urandom_range(0, 9) == 0);
            if (r < 3) begin
                repeat (25) cyc();
            end else if (r < 55) begin
                cyc();
            end else if (r < 85) begin
                cidx = (cidx + 1) % N;
                in_p = jenc(cidx);
                cyc();
            end else if (r < 92) begin
                cidx = $urandom_range(0, N - 1);
                in_p = jenc(cidx);
                cyc();
            end else begin
                in_p = W'($urandom);
                cyc();
            end
        end
        clear = 1'b0;

        // Over 300 laps with a step every cycle: LAPS saturates.
        enable = 1'b1;
        in_p   = '0;
        do_reset();
        cyc();
        cyc();
        for (int s = 1; s <= 6020; s++) begin
            in_p   = jenc(s % N);
            enable = 1'($urandom_range(0, 1));
            cyc();
        end
        chk("sat_laps", int'(laps), 255);

        // Reset mid-cycle clears everything at once; a fresh hunt follows.
        cyc();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_index",  int'(index),  0);
        chk("rst_valid",  int'(valid),  0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_step",   int'(step),   0);
        chk("rst_error",  int'(error),  0);
        chk("rst_laps",   int'(laps),   0);
        in_p = jenc(7);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        cyc();
        cyc();
        chk("rehunt_locked", int'(locked), 1);
        chk("rehunt_index",  int'(index),  7);
        chk("rehunt_laps",   int'(laps),   0);
        repeat (5) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/johnson_checker.md
JOHNSON_CHECKER -- requirements
Module: johnson_checker

Interface
REQ-001 The block SHALL use a single clock and asynchronous active-low reset: CLK is the sole clock; RSTn is asynchronous, active-low.
REQ-002 Parameter: width, 10, bit width of the monitored Johnson-coded bus; legal range 2..16.
REQ-003 Parameter: modulo, 10, nominal ENABLE cycles between generator steps; legal range 1..255.
REQ-004 CLK  input  1  rising-edge clock.
REQ-005 RSTn  input  1  asynchronous active-low reset.
REQ-006 ENABLE  input  1  time-base qualifier; the timeout counter advances only when high.
REQ-007 IN_P  input  width  parallel Johnson code under observation.
REQ-008 CLEAR  input  1  synchronous request to leave ERROR and restart the hunt.
REQ-009 INDEX  output  5  decoded position 0..2*width-1 of the last valid code.
REQ-010 VALID  output  1  high while the last sampled code is a legal Johnson code.
REQ-011 LOCKED  output  1  high while the FSM is in CHECK.
REQ-012 STEP  output  1  one-cycle pulse per legal step in CHECK.
REQ-013 ERROR  output  1  sticky error flag, high while the FSM is in ERROR.
REQ-014 LAPS  output  8  saturating count of completed 2*width-step cycles.

Function
REQ-015 Code map: shift is toward the MSB with inverted feedback; index k in 0..width is k ones in the LSBs; index k in width+1..2*width-1 is zeros in the (k-width) LSBs and ones above.
REQ-016 Any other pattern SHALL be illegal; e.g. width=10: 0000000000->0, 0000000111->3, 1111111111->10, 1111111000->13, 1000000000->19, 0000000101 illegal.
REQ-017 IN_P SHALL be registered every cycle (stage s1); decode and FSM use s1 and the previous s1 value (s2); registered outputs update one edge after s1 captures the code (2-edge input-to-output latency).
REQ-018 A change event SHALL be s1 != s2.
REQ-019 FSM states: HUNT, CHECK, ERROR; reset state HUNT.
REQ-020 HUNT: on a change event, or the first sample after reset, whose s1 code is legal -> CHECK, with expected = (index+1) mod 2*width; illegal codes keep HUNT.
REQ-021 CHECK, change event, legal code with index == expected -> stay in CHECK, STEP=1, expected advances, timeout counter clears.
REQ-022 CHECK, change event, illegal code or index != expected -> ERROR.
REQ-023 CHECK, no change: the timeout counter increments on ENABLE; reaching 2*modulo -> ERROR.
REQ-024 ERROR: held until CLEAR=1; CLEAR -> HUNT on the next edge and clears the timeout counter; ERROR and LAPS remain unaffected by CLEAR in HUNT and CHECK.
REQ-025 CLEAR and a CHECK error on the same edge -> ERROR wins.
REQ-026 INDEX SHALL update only when s1 is legal; otherwise it holds its last value and VALID=0.
REQ-027 LAPS SHALL increment on a legal CHECK step from 2*width-1 to 0 and saturate at 255.
REQ-028 An unchanged code SHALL never raise STEP or ERROR, except by timeout.

Reset
REQ-029 RSTn low SHALL immediately force: FSM=HUNT, s1=s2=0, timeout counter=0, INDEX=0, VALID=0, LOCKED=0, STEP=0, ERROR=0, LAPS=0.
REQ-030 Reset asserted mid-CHECK or in ERROR SHALL discard all history; after release, behaviour follows REQ-020 from a fresh hunt.

Verification
REQ-031 Reset, then IN_P=0000000000 held, ENABLE=1 -> LOCKED=1, INDEX=0, VALID=1 after 2 edges; ERROR=1 exactly 20 ENABLE cycles later.
REQ-032 Drive the legal sequence 0..19..0 stepping every 10 ENABLE cycles -> STEP pulses 20 times, LAPS=1 after the wrap, ERROR=0.
REQ-033 In CHECK at index 3, drive 0000011111 (index 5) -> ERROR=1, LOCKED=0, INDEX=5, STEP=0.
REQ-034 In CHECK, drive 0000000101 -> ERROR=1, VALID=0, INDEX holds its prior value.
REQ-035 In ERROR, pulse CLEAR with IN_P=1111111111 -> HUNT, then CHECK with INDEX=10, ERROR=0; LAPS is unchanged.
REQ-036 Run 300 full cycles -> LAPS saturates at 255; assert RSTn mid-cycle -> all outputs are 0 immediately.
